// File: rtl/branch_target_predictor_pkg.sv
// Shared types for the branch target predictor: FSM states and 2-bit counter encodings.
package btb_pkg;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_READY = 1'b1
    } btb_state_e;

    typedef logic [1:0] ctr_t;

    localparam ctr_t STRONG_NT        = 2'b00;
    localparam ctr_t WEAK_NT          = 2'b01;
    localparam ctr_t WEAK_T           = 2'b10;
    localparam ctr_t STRONG_T         = 2'b11;
    localparam ctr_t CTR_INIT_DEFAULT = WEAK_T;

    function automatic logic ctr_predicts_taken(ctr_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Fetch lookup and resolved-branch update bus between the pipeline (master) and the predictor (slave).
interface btb_if #(
    parameter int ADDRESS_WIDTH = 22
) ();
    logic [ADDRESS_WIDTH-1:0] i_pc;
    logic                     i_ALU_valid;
    logic [ADDRESS_WIDTH-1:0] i_ALU_pc;
    logic                     i_ALU_taken;
    logic [ADDRESS_WIDTH-1:0] i_ALU_target;
    logic                     o_hit;
    logic                     o_predict_taken;
    logic [ADDRESS_WIDTH-1:0] o_target;
    logic                     o_ready;

    modport master (
        output i_pc, i_ALU_valid, i_ALU_pc, i_ALU_taken, i_ALU_target,
        input  o_hit, o_predict_taken, o_target, o_ready
    );

    modport slave (
        input  i_pc, i_ALU_valid, i_ALU_pc, i_ALU_taken, i_ALU_target,
        output o_hit, o_predict_taken, o_target, o_ready
    );
endinterface

// File: rtl/branch_target_predictor_sat_counter.sv
// 2-bit saturating counter next-value function, purely combinational.
module btb_sat_counter
    import btb_pkg::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    output ctr_t next_ctr_o
);

    always_comb begin
        next_ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != STRONG_T) next_ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != STRONG_NT) next_ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer: zero-latency lookup, one-cycle update, walks all valid bits clear on reset/flush.
// No backpressure: updates arriving while not ready or during a flush request are dropped.
module branch_target_predictor
    import btb_pkg::*;
#(
    parameter int   ADDRESS_WIDTH = 22,
    parameter int   INDEX_WIDTH   = 8,
    parameter ctr_t CTR_INIT      = CTR_INIT_DEFAULT
) (
    input  logic  i_Clk,
    input  logic  i_Reset,
    input  logic  i_Flush,
    btb_if.slave  bus
);

    localparam int TAG_WIDTH = ADDRESS_WIDTH - INDEX_WIDTH;
    localparam int ENTRIES   = 2 ** INDEX_WIDTH;

    if (INDEX_WIDTH >= ADDRESS_WIDTH) begin : g_bad_width
        $error("INDEX_WIDTH must be less than ADDRESS_WIDTH");
    end

    btb_state_e             state_q;
    logic                   ready_q;
    logic [INDEX_WIDTH-1:0] flush_idx_q;

    logic [ENTRIES-1:0]       valid_q;
    logic [TAG_WIDTH-1:0]     tag_q    [ENTRIES];
    logic [ADDRESS_WIDTH-1:0] target_q [ENTRIES];
    ctr_t                     ctr_q    [ENTRIES];

    logic [INDEX_WIDTH-1:0] lk_idx;
    logic [TAG_WIDTH-1:0]   lk_tag;
    logic                   lk_hit;

    logic [INDEX_WIDTH-1:0] upd_idx;
    logic [TAG_WIDTH-1:0]   upd_tag;
    logic                   upd_hit;
    ctr_t                   ctr_d;

    assign lk_idx = bus.i_pc[INDEX_WIDTH-1:0];
    assign lk_tag = bus.i_pc[ADDRESS_WIDTH-1:INDEX_WIDTH];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    // Lookup reads the pre-edge arrays, so a same-cycle update is only seen next cycle.
    assign bus.o_hit           = ready_q && lk_hit;
    assign bus.o_predict_taken = ready_q && lk_hit && ctr_predicts_taken(ctr_q[lk_idx]);
    assign bus.o_target        = target_q[lk_idx];
    assign bus.o_ready         = ready_q;

    assign upd_idx = bus.i_ALU_pc[INDEX_WIDTH-1:0];
    assign upd_tag = bus.i_ALU_pc[ADDRESS_WIDTH-1:INDEX_WIDTH];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    btb_sat_counter u_sat_counter (
        .ctr_i      (ctr_q[upd_idx]),
        .taken_i    (bus.i_ALU_taken),
        .next_ctr_o (ctr_d)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Flush) begin
            state_q     <= ST_FLUSH;
            ready_q     <= 1'b0;
            flush_idx_q <= '0;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    valid_q[flush_idx_q] <= 1'b0;
                    flush_idx_q          <= flush_idx_q + 1'b1;
                    if (flush_idx_q == INDEX_WIDTH'(ENTRIES - 1)) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (bus.i_ALU_valid) begin
                        if (upd_hit) begin
                            ctr_q[upd_idx] <= ctr_d;
                            if (bus.i_ALU_taken) target_q[upd_idx] <= bus.i_ALU_target;
                        end else if (bus.i_ALU_taken) begin
                            // Taken miss evicts whatever occupied this index.
                            valid_q[upd_idx]  <= 1'b1;
                            tag_q[upd_idx]    <= upd_tag;
                            target_q[upd_idx] <= bus.i_ALU_target;
                            ctr_q[upd_idx]    <= CTR_INIT;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_FLUSH;
                    ready_q     <= 1'b0;
                    flush_idx_q <= '0;
                end
            endcase
        end
    end

endmodule
